// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue
// Turns the raw scan-code byte stream from ps2_keyboard into complete key events.
// A two-process parser strips E0/F0 prefixes and swallows the E1 pause sequence.
// Modifier, caps-lock and held-key state are updated in the cycle an event is decoded.
// Events land in a small FIFO that is read through a valid/ready port.
module ps2_key_event_queue #(
    parameter int DEPTH         = 8,     // event FIFO entries, power of two, >= 2
    parameter bit REPEAT_FILTER = 1'b1,  // drop repeated makes of the held key
    parameter bit MAKE_ONLY     = 1'b0   // breaks update modifiers but are not queued
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic [7:0]             code_in,
    input  logic                   code_valid,
    output logic                   code_pop,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [7:0]             evt_code,
    output logic                   evt_ext,
    output logic                   evt_break,
    output logic [3:0]             evt_mods,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   overflow
);

    localparam int            AW         = $clog2(DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [7:0] C_EXT       = 8'hE0;
    localparam logic [7:0] C_BRK       = 8'hF0;
    localparam logic [7:0] C_PAUSE     = 8'hE1;
    localparam logic [7:0] C_PAUSE_KEY = 8'h77;
    localparam logic [7:0] C_LSHIFT    = 8'h12;
    localparam logic [7:0] C_RSHIFT    = 8'h59;
    localparam logic [7:0] C_CTRL      = 8'h14;
    localparam logic [7:0] C_ALT       = 8'h11;
    localparam logic [7:0] C_CAPS      = 8'h58;

    // The pause sequence is E1 followed by seven more bytes; the count
    // indexes those seven, so the last one is seen at count 6.
    localparam logic [2:0] PAUSE_LAST = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_PAUSE
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] mods;   // {caps, alt, ctrl, shift}
    } entry_t;

    // Input handshake
    logic          r_code_pop;
    logic          w_consume;
    logic          w_discard;

    // Parser
    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_pause_cnt;
    logic [2:0]    w_pause_cnt_nxt;
    logic          w_event;
    logic [7:0]    w_ev_code;
    logic          w_ev_ext;
    logic          w_ev_brk;

    // Modifier and held-key tracking
    logic          r_lshift, r_rshift, r_ctrl, r_alt, r_caps;
    logic          w_lshift_nxt, w_rshift_nxt, w_ctrl_nxt, w_alt_nxt, w_caps_nxt;
    logic          r_held_valid;
    logic          r_held_ext;
    logic [7:0]    r_held_code;
    logic          w_held_match;
    logic          w_repeat;

    // Event FIFO
    entry_t        r_mem [DEPTH];
    entry_t        w_entry;
    entry_t        w_head;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_enq_req;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // A byte is taken only while no pop pulse is outstanding, so ps2_keyboard
    // has a cycle to advance its own buffer before the next sample.
    assign w_consume = code_valid && !r_code_pop;
    assign w_discard = code_in inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};
    assign code_pop  = r_code_pop;

    // Pop pulse follows each consumed byte by exactly one cycle.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every register
        // samples the values from before this edge, independent of block order.
        if (!clrn) begin
            r_code_pop <= 1'b0;
        end else begin
            r_code_pop <= w_consume;
        end
    end

    // Parser state register; reset also abandons any partial prefix or pause.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state     <= S_IDLE;
            r_pause_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pause_cnt <= w_pause_cnt_nxt;
        end
    end

    // Parser next state and decoded event for the byte consumed this cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the branches below can leave one holding its old value.
        w_state_nxt     = r_state;
        w_pause_cnt_nxt = r_pause_cnt;
        w_event         = 1'b0;
        w_ev_code       = code_in;
        w_ev_ext        = 1'b0;
        w_ev_brk        = 1'b0;

        if (w_consume) begin
            if (r_state == S_PAUSE) begin
                // Every byte of the pause sequence is swallowed, including
                // bytes that would otherwise be discarded or act as prefixes.
                if (r_pause_cnt == PAUSE_LAST) begin
                    w_event         = 1'b1;
                    w_ev_code       = C_PAUSE_KEY;
                    w_ev_ext        = 1'b1;
                    w_state_nxt     = S_IDLE;
                    w_pause_cnt_nxt = 3'd0;
                end else begin
                    w_pause_cnt_nxt = r_pause_cnt + 3'd1;
                end
            end else if (w_discard) begin
                w_state_nxt = S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (code_in == C_EXT) begin
                            w_state_nxt = S_EXT;
                        end else if (code_in == C_BRK) begin
                            w_state_nxt = S_BRK;
                        end else if (code_in == C_PAUSE) begin
                            w_state_nxt     = S_PAUSE;
                            w_pause_cnt_nxt = 3'd0;
                        end else begin
                            w_event     = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_EXT: begin
                        if (code_in == C_BRK) begin
                            w_state_nxt = S_EXTBRK;
                        end else if (code_in != C_EXT) begin
                            w_event     = 1'b1;
                            w_ev_ext    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        if (code_in == C_EXT) begin
                            w_state_nxt = S_EXTBRK;
                        end else if (code_in != C_BRK) begin
                            w_event     = 1'b1;
                            w_ev_brk    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    S_EXTBRK: begin
                        if (code_in != C_EXT && code_in != C_BRK) begin
                            w_event     = 1'b1;
                            w_ev_ext    = 1'b1;
                            w_ev_brk    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    // A make of the key already held is a typematic repeat; breaks never are.
    assign w_held_match = r_held_valid && (r_held_ext == w_ev_ext) && (r_held_code == w_ev_code);
    assign w_repeat     = w_event && !w_ev_brk && w_held_match;

    // Modifier values after the current event; E0 variants count as the same key.
    always_comb begin
        w_lshift_nxt = r_lshift;
        w_rshift_nxt = r_rshift;
        w_ctrl_nxt   = r_ctrl;
        w_alt_nxt    = r_alt;
        w_caps_nxt   = r_caps;
        if (w_event) begin
            unique case (w_ev_code)
                C_LSHIFT: w_lshift_nxt = !w_ev_brk;
                C_RSHIFT: w_rshift_nxt = !w_ev_brk;
                C_CTRL:   w_ctrl_nxt   = !w_ev_brk;
                C_ALT:    w_alt_nxt    = !w_ev_brk;
                C_CAPS: begin
                    if (!w_ev_brk && !w_repeat) begin
                        w_caps_nxt = !r_caps;
                    end
                end
                default: ;
            endcase
        end
    end

    // Modifier registers follow every decoded event, queued or not.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_ctrl   <= 1'b0;
            r_alt    <= 1'b0;
            r_caps   <= 1'b0;
        end else begin
            r_lshift <= w_lshift_nxt;
            r_rshift <= w_rshift_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_alt    <= w_alt_nxt;
            r_caps   <= w_caps_nxt;
        end
    end

    // Held key: loaded by every make, cleared by the break of that same key.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_held_valid <= 1'b0;
            r_held_ext   <= 1'b0;
            r_held_code  <= 8'h00;
        end else if (w_event) begin
            if (!w_ev_brk) begin
                r_held_valid <= 1'b1;
                r_held_ext   <= w_ev_ext;
                r_held_code  <= w_ev_code;
            end else if (w_held_match) begin
                r_held_valid <= 1'b0;
            end
        end
    end

    // Queue decision. Fullness is judged at the start of the cycle, so a pop in
    // the same cycle never makes room for an event that arrived on a full FIFO.
    assign w_enq_req = w_event && !(MAKE_ONLY && w_ev_brk) && !(REPEAT_FILTER && w_repeat);
    assign w_full    = (r_count == FULL_COUNT);
    assign w_push    = w_enq_req && !w_full;
    assign w_pop     = evt_valid && evt_ready;

    assign w_entry.code = w_ev_code;
    assign w_entry.ext  = w_ev_ext;
    assign w_entry.brk  = w_ev_brk;
    assign w_entry.mods = {w_caps_nxt, w_alt_nxt, w_ctrl_nxt, w_lshift_nxt | w_rshift_nxt};

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers and count are,
        // and the read side masks the head whenever the FIFO is empty.
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; pointers wrap as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_enq_req && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign evt_count = r_count;
    assign overflow  = r_overflow;

    // Head entry is presented only while the FIFO holds something; otherwise all zero.
    always_comb begin
        evt_valid = (r_count != '0);
        evt_code  = 8'h00;
        evt_ext   = 1'b0;
        evt_break = 1'b0;
        evt_mods  = 4'h0;
        if (evt_valid) begin
            evt_code  = w_head.code;
            evt_ext   = w_head.ext;
            evt_break = w_head.brk;
            evt_mods  = w_head.mods;
        end
    end

endmodule
